// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline/hazard-controller signal bundle
// master = pipeline side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int PC_W   = 32
);
   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic              ex_reg_write_enable;
   logic [REG_AW-1:0] ex_alu_dest;
   logic              ex_mem_rd;
   logic              ex_mem_wr;
   logic              ex_load_pc;
   logic [PC_W-1:0]   ex_load_pc_val;
   logic              mem_ready;

   logic              flush;
   logic              stall_fetch;
   logic              stall_decode;
   logic              stall_ex;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;

   modport master (
      output id_valid, id_src1, id_src2,
      output ex_reg_write_enable, ex_alu_dest, ex_mem_rd, ex_mem_wr,
      output ex_load_pc, ex_load_pc_val, mem_ready,
      input  flush, stall_fetch, stall_decode, stall_ex,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  id_valid, id_src1, id_src2,
      input  ex_reg_write_enable, ex_alu_dest, ex_mem_rd, ex_mem_wr,
      input  ex_load_pc, ex_load_pc_val, mem_ready,
      output flush, stall_fetch, stall_decode, stall_ex,
      output redirect_valid, redirect_pc
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (redirect, load-use, memory wait)
// Optional statistics counters enabled by HAZARD_STATS_EN.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_AW       = 5,
   parameter int PC_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
`ifdef HAZARD_STATS_EN
   input  logic              stat_clr,
   output logic [15:0]       stat_stall_cnt,
   output logic [15:0]       stat_flush_cnt,
   output logic [15:0]       stat_redirect_cnt,
`endif
   hazard_ctrl_if.slave      hz
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;

   logic [REG_AW-1:0] src1, src2, dest;
   logic [PC_W-1:0]   target;
   logic              mem_busy;
   logic              load_use;

   logic              flush_c;
   logic              stall_fe_c;
   logic              stall_de_c;
   logic              stall_ex_c;
   logic              redir_c;

   assign src1   = hz.id_src1;
   assign src2   = hz.id_src2;
   assign dest   = hz.ex_alu_dest;
   assign target = hz.ex_load_pc_val;

   assign mem_busy = (hz.ex_mem_rd | hz.ex_mem_wr) & ~hz.mem_ready;

   assign load_use = hz.ex_mem_rd & hz.ex_reg_write_enable & (dest != '0) &
                     hz.id_valid & ((src1 == dest) | (src2 == dest));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flush_c    = 1'b0;
      stall_fe_c = 1'b0;
      stall_de_c = 1'b0;
      stall_ex_c = 1'b0;
      redir_c    = 1'b0;

      case (state_q)
         // MEM_WAIT with mem_ready behaves exactly like RUN
         RUN, MEM_WAIT: begin
            if (mem_busy) begin
               stall_fe_c = 1'b1;
               stall_de_c = 1'b1;
               stall_ex_c = 1'b1;
               state_d    = MEM_WAIT;
            end else if (hz.ex_load_pc) begin
               redir_c = 1'b1;
               flush_c = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
               if (load_use) begin
                  stall_fe_c = 1'b1;
                  stall_de_c = 1'b1;
                  flush_c    = 1'b1;
               end
            end
         end

         // Wrong-path instructions are squashed; redirects and load-use ignored
         FLUSH: begin
            flush_c = 1'b1;
            if (cnt_q <= 3'd1) begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end

         default: begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      endcase
   end

   assign hz.flush          = ~rst & flush_c;
   assign hz.stall_fetch    = ~rst & stall_fe_c;
   assign hz.stall_decode   = ~rst & stall_de_c;
   assign hz.stall_ex       = ~rst & stall_ex_c;
   assign hz.redirect_valid = ~rst & redir_c;
   assign hz.redirect_pc    = (~rst & redir_c) ? target : '0;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_stall_cnt    <= 16'd0;
         stat_flush_cnt    <= 16'd0;
         stat_redirect_cnt <= 16'd0;
      end else if (stat_clr) begin
         stat_stall_cnt    <= 16'd0;
         stat_flush_cnt    <= 16'd0;
         stat_redirect_cnt <= 16'd0;
      end else begin
         if (hz.stall_fetch && stat_stall_cnt != 16'hFFFF)
            stat_stall_cnt <= stat_stall_cnt + 16'd1;
         if (hz.flush && stat_flush_cnt != 16'hFFFF)
            stat_flush_cnt <= stat_flush_cnt + 16'd1;
         if (hz.redirect_valid && stat_redirect_cnt != 16'hFFFF)
            stat_redirect_cnt <= stat_redirect_cnt + 16'd1;
      end
   end
`endif

endmodule
